jtframe_cab_inputs: RTL and testbench

- Parametrised cabinet-input merger between the MiSTer hps_io outputs and the game core.
- Decodes PS/2 key events and merges them with N joystick words.
- Produces registered, active-low per-player joystick/start/coin signals and a latched pause level.
- Generalises the hand-written per-core keyboard/joystick logic to any player and button count, and adds coin pulse stretching plus a spurious-event guard at reset.

---
 rtl/jtframe_cab_inputs.sv | 160 ++++++++++++++++
 tb/tb_jtframe_cab_inputs.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/jtframe_cab_inputs.sv
// Cabinet input merger: PS/2 keys plus joystick words, giving registered active-low controls.
// Optional build macro JTFRAME_AUTOFIRE_EN adds free-running autofire on button0.
module jtframe_cab_inputs #(
    parameter int          PLAYERS      = 2,
    parameter int          BUTTONS      = 1,
    parameter logic [15:0] COIN_CYCLES  = 16'd4000,
    parameter int          AUTOFIRE_DIV = 20
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [10:0]                    ps2_key,
    input  logic [16*PLAYERS-1:0]          joy_in,
    input  logic                           pause_clr,
    output logic [(4+BUTTONS)*PLAYERS-1:0] joystick_n,
    output logic [PLAYERS-1:0]             start_n,
    output logic [PLAYERS-1:0]             coin_n,
    output logic                           pause
);

    localparam int JW = 4 + BUTTONS;
    localparam int CW = $clog2(int'(COIN_CYCLES) + 1);
    localparam logic [CW-1:0] COIN_LOAD = CW'(COIN_CYCLES);

    logic [3:0] key_dir;
    logic [2:0] key_btn;
    logic [1:0] key_start;
    logic [1:0] key_coin;
    logic       key_pause;
    logic       tog;
    logic       init;

    logic [JW*PLAYERS-1:0] joy_req;
    logic [PLAYERS-1:0]    start_req;
    logic [PLAYERS-1:0]    coin_req;
    logic                  pause_req;
    logic                  pause_prev;
    logic [PLAYERS-1:0]    coin_prev;
    logic [CW-1:0]         coin_cnt [PLAYERS];
    logic                  af_gate;

    logic unused;
    assign unused = ^{ps2_key[8], joy_in};

    // The first cycle after reset only samples the toggle, so a stale event is not decoded.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            key_dir   <= '0;
            key_btn   <= '0;
            key_start <= '0;
            key_coin  <= '0;
            key_pause <= 1'b0;
            tog       <= 1'b0;
            init      <= 1'b1;
        end else if (init) begin
            tog  <= ps2_key[10];
            init <= 1'b0;
        end else if (ps2_key[10] != tog) begin
            tog <= ps2_key[10];
            case (ps2_key[7:0])
                8'h75: key_dir[3]   <= ps2_key[9];
                8'h72: key_dir[2]   <= ps2_key[9];
                8'h6B: key_dir[1]   <= ps2_key[9];
                8'h74: key_dir[0]   <= ps2_key[9];
                8'h14: key_btn[0]   <= ps2_key[9];
                8'h11: key_btn[1]   <= ps2_key[9];
                8'h29: key_btn[2]   <= ps2_key[9];
                8'h05: key_start[0] <= ps2_key[9];
                8'h06: key_start[1] <= ps2_key[9];
                8'h04: key_coin[0]  <= ps2_key[9];
                8'h03: key_coin[1]  <= ps2_key[9];
                8'h0C: key_pause    <= ps2_key[9];
                default: ;
            endcase
        end
    end

`ifdef JTFRAME_AUTOFIRE_EN
    logic [AUTOFIRE_DIV:0] af_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) af_cnt <= '0;
        else     af_cnt <= af_cnt + 1'b1;
    end

    assign af_gate = ~af_cnt[AUTOFIRE_DIV];
`else
    assign af_gate = 1'b1;
`endif

    logic [7:0] kbtn;
    logic [3:0] kstart;
    logic [3:0] kcoin;

    assign kbtn   = {5'd0, key_btn};
    assign kstart = {2'd0, key_start};
    assign kcoin  = {2'd0, key_coin};
    assign pause_req = key_pause | joy_in[14];

    // Keyboard keys only ever belong to player 0, except start/coin for player 1.
    always_comb begin
        joy_req   = '0;
        start_req = '0;
        coin_req  = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            joy_req[p*JW +: 4] = joy_in[16*p +: 4] | ((p == 0) ? key_dir : 4'd0);
            for (int b = 0; b < BUTTONS; b++) begin
                joy_req[p*JW+4+b] = joy_in[16*p+4+b] | ((p == 0) & kbtn[b]);
            end
            joy_req[p*JW+4] = joy_req[p*JW+4] & af_gate;
            start_req[p] = joy_in[16*p+12] | kstart[p];
            coin_req[p]  = joy_in[16*p+13] | kcoin[p];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            joystick_n <= '1;
            start_n    <= '1;
        end else begin
            joystick_n <= ~joy_req;
            start_n    <= ~start_req;
        end
    end

    // A rising coin edge (re)loads the stretch counter; a held coin stays low afterwards.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            coin_n    <= '1;
            coin_prev <= '0;
            for (int p = 0; p < PLAYERS; p++) coin_cnt[p] <= '0;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                coin_prev[p] <= coin_req[p];
                if (coin_req[p] && !coin_prev[p]) begin
                    coin_cnt[p] <= COIN_LOAD;
                    coin_n[p]   <= 1'b0;
                end else if (coin_cnt[p] != '0) begin
                    coin_cnt[p] <= coin_cnt[p] - CW'(1);
                    coin_n[p]   <= (coin_cnt[p] == CW'(1)) ? ~coin_req[p] : 1'b0;
                end else begin
                    coin_n[p] <= ~coin_req[p];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pause      <= 1'b0;
            pause_prev <= 1'b0;
        end else begin
            pause_prev <= pause_req;
            if (pause_clr)
                pause <= 1'b0;
            else if (pause_req && !pause_prev)
                pause <= ~pause;
        end
    end

endmodule

// File: tb/tb_jtframe_cab_inputs.sv
// Scoreboard bench for jtframe_cab_inputs: directed scenarios then random key/joystick traffic.
module tb_jtframe_cab_inputs;

    localparam int P  = 2;
    localparam int B  = 2;
    localparam int JW = 4 + B;
    localparam int C  = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic [10:0]       ps2_key;
    logic [16*P-1:0]   joy_in;
    logic              pause_clr;
    logic [JW*P-1:0]   joystick_n;
    logic [P-1:0]      start_n;
    logic [P-1:0]      coin_n;
    logic              pause;

    jtframe_cab_inputs #(
        .PLAYERS(P), .BUTTONS(B), .COIN_CYCLES(16'(C)), .AUTOFIRE_DIV(2)
    ) dut (
        .clk(clk), .rst(rst), .ps2_key(ps2_key), .joy_in(joy_in),
        .pause_clr(pause_clr), .joystick_n(joystick_n), .start_n(start_n),
        .coin_n(coin_n), .pause(pause)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [JW*P-1:0] joy;
        logic [P-1:0]    st;
        logic [P-1:0]    cn;
        logic            pz;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    // Reference model state: pressed flag per scan code, coin time left, pause level.
    bit   keys [0:255];
    bit   m_init, m_tog;
    int   rem [P];
    bit   cprev [P];
    bit   pprev, pz;
    logic [10:0]     cur_ps2;
    logic [16*P-1:0] cur_joy;

    function automatic bit kb(input int p, input int b);
        logic [7:0] codes [3];
        codes[0] = 8'h14; codes[1] = 8'h11; codes[2] = 8'h29;
        if (p != 0 || b > 2) return 1'b0;
        return keys[codes[b]];
    endfunction

    task automatic model(input logic r, input logic [10:0] k,
                         input logic [16*P-1:0] j, input logic c);
        exp_t e;
        bit rq, st, cr, pr;
        if (r) begin
            foreach (keys[i]) keys[i] = 1'b0;
            m_init = 1; m_tog = 0; pprev = 0; pz = 0;
            for (int p = 0; p < P; p++) begin rem[p] = 0; cprev[p] = 0; end
            e.joy = '1; e.st = '1; e.cn = '1; e.pz = 1'b0;
        end else begin
            for (int p = 0; p < P; p++) begin
                e.joy[p*JW+0] = !(j[16*p+0] | (p == 0 && keys[8'h74]));
                e.joy[p*JW+1] = !(j[16*p+1] | (p == 0 && keys[8'h6B]));
                e.joy[p*JW+2] = !(j[16*p+2] | (p == 0 && keys[8'h72]));
                e.joy[p*JW+3] = !(j[16*p+3] | (p == 0 && keys[8'h75]));
                for (int b = 0; b < B; b++) begin
                    rq = j[16*p+4+b] | kb(p, b);
                    e.joy[p*JW+4+b] = !rq;
                end
                st = j[16*p+12] | (p == 0 ? keys[8'h05] : p == 1 ? keys[8'h06] : 1'b0);
                e.st[p] = !st;
                cr = j[16*p+13] | (p == 0 ? keys[8'h04] : p == 1 ? keys[8'h03] : 1'b0);
                if (cr && !cprev[p]) rem[p] = C;
                else if (rem[p] > 0) rem[p]--;
                cprev[p] = cr;
                e.cn[p] = !(rem[p] > 0 || cr);
            end
            pr = keys[8'h0C] | j[14];
            if (c) pz = 0;
            else if (pr && !pprev) pz = !pz;
            pprev = pr;
            e.pz = pz;
            if (m_init) begin
                m_tog = k[10]; m_init = 0;
            end else if (k[10] != m_tog) begin
                m_tog = k[10];
                keys[k[7:0]] = k[9];
            end
        end
        q.push_back(e);
    endtask

    task automatic step(input logic r, input logic c);
        @(negedge clk);
        rst = r; ps2_key = cur_ps2; joy_in = cur_joy; pause_clr = c;
        model(r, cur_ps2, cur_joy, c);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0);
    endtask

    task automatic key(input logic [7:0] code, input logic pressed);
        cur_ps2 = {~cur_ps2[10], pressed, 1'b0, code};
        step(1'b0, 1'b0);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                total++;
                if (joystick_n !== e.joy) begin
                    bad++;
                    $display("FAIL joystick_n got=%h want=%h t=%0t", joystick_n, e.joy, $time);
                end
                total++;
                if (start_n !== e.st) begin
                    bad++;
                    $display("FAIL start_n got=%b want=%b t=%0t", start_n, e.st, $time);
                end
                total++;
                if (coin_n !== e.cn) begin
                    bad++;
                    $display("FAIL coin_n got=%b want=%b t=%0t", coin_n, e.cn, $time);
                end
                total++;
                if (pause !== e.pz) begin
                    bad++;
                    $display("FAIL pause got=%b want=%b t=%0t", pause, e.pz, $time);
                end
            end
        end
    end

    initial begin
        cur_ps2 = {1'b1, 1'b1, 1'b0, 8'h14};
        cur_joy = '0;
        rst = 1'b1; ps2_key = cur_ps2; joy_in = '0; pause_clr = 1'b0;
        step(1'b1, 1'b0);
        step(1'b1, 1'b0);
        idle(4);
        key(8'h75, 1'b1); idle(3);
        key(8'h75, 1'b0); idle(3);
        key(8'h29, 1'b1); idle(2);
        key(8'h06, 1'b1); idle(2);
        key(8'h06, 1'b0); idle(2);
        cur_joy[16+4] = 1'b1; idle(2);
        cur_joy = '0; idle(2);
        cur_joy[13] = 1'b1; idle(1);
        cur_joy = '0; idle(12);
        cur_joy[13] = 1'b1; idle(1);
        cur_joy = '0; idle(4);
        cur_joy[13] = 1'b1; idle(1);
        cur_joy = '0; idle(15);
        key(8'h03, 1'b1); idle(14);
        key(8'h03, 1'b0); idle(3);
        for (int i = 0; i < 2; i++) begin
            key(8'h0C, 1'b1); idle(2);
            key(8'h0C, 1'b0); idle(2);
        end
        cur_joy[14] = 1'b1;
        step(1'b0, 1'b1);
        cur_joy = '0; idle(3);
        cur_joy[13] = 1'b1; idle(3);
        step(1'b1, 1'b0);
        cur_joy = '0; idle(3);
        for (int i = 0; i < 2000; i++) begin
            logic [7:0] codes [13];
            codes = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29,
                      8'h05, 8'h06, 8'h04, 8'h03, 8'h0C, 8'h00};
            if ($urandom_range(0, 3) == 0) begin
                logic [7:0] cd;
                cd = codes[$urandom_range(0, 12)];
                if (cd == 8'h00) cd = 8'($urandom);
                cur_ps2 = {~cur_ps2[10], 1'($urandom), 1'($urandom), cd};
            end
            if ($urandom_range(0, 3) == 0)
                cur_joy[$urandom_range(0, 16*P-1)] ^= 1'b1;
            step($urandom_range(0, 299) == 0, $urandom_range(0, 39) == 0);
        end
        repeat (2) @(posedge clk);
        #2;
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d want=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
